// File: rtl/ddfs_pkg.sv
// Shared types and constants for the DDFS sweep scheduler.
package ddfs_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_LOOP   = 1'b1;

    localparam int FTW_W_DEF   = 16;
    localparam int DWELL_W_DEF = 16;

endpackage

// File: rtl/ddfs_sweep_ctrl_dwell_timer.sv
// Dwell down-counter: load a value, count to zero while enabled, flag terminal count.
module dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    output logic               expire
);

    logic [DWELL_W-1:0] count;

    assign expire = en && (count == '0);

    // Load takes priority; otherwise count down and stop at zero.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/ddfs_sweep_ctrl.sv
// Sweep scheduler: steps the tuning word from start to stop, one value per dwell period.
//
// state | meaning
// IDLE  | no sweep active, waiting for start
// DWELL | holding ftw_out; on terminal count step, reload (loop) or finish
module ddfs_sweep_ctrl
    import ddfs_pkg::*;
#(
    parameter int FTW_W   = FTW_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [FTW_W-1:0]   ftw_start,
    input  logic [FTW_W-1:0]   ftw_step,
    input  logic [FTW_W-1:0]   ftw_stop,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FTW_W-1:0]   ftw_out,
    output logic               ftw_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    state_t             state;
    logic               mode_q;
    logic [FTW_W-1:0]   start_q;
    logic [FTW_W-1:0]   step_q;
    logic [FTW_W-1:0]   stop_q;
    logic [DWELL_W-1:0] dwell_q;

    logic [DWELL_W-1:0] eff_dwell;
    logic [FTW_W:0]     sum;
    logic               pass_end;
    logic               go;
    logic               expire;
    logic               timer_load;
    logic [DWELL_W-1:0] timer_load_val;

    assign eff_dwell = (dwell == '0) ? DWELL_ONE : dwell;
    // Carry is kept so an overflowing step clamps to stop instead of wrapping.
    assign sum       = {1'b0, ftw_out} + {1'b0, step_q};
    assign pass_end  = (step_q == '0) || (ftw_out >= stop_q);
    assign go        = (state == IDLE) && start && !abort;

    // Reload on sweep start and on every terminal count that emits a new value.
    assign timer_load     = go || (expire && !abort && (!pass_end || (mode_q == MODE_LOOP)));
    assign timer_load_val = go ? (eff_dwell - DWELL_ONE) : (dwell_q - DWELL_ONE);

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk_in   (clk_in),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_load_val),
        .en       (state == DWELL),
        .expire   (expire)
    );

    // Sweep FSM with shadow registers and registered outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mode_q    <= MODE_SINGLE;
            start_q   <= '0;
            step_q    <= '0;
            stop_q    <= '0;
            dwell_q   <= '0;
            ftw_out   <= '0;
            ftw_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            ftw_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        mode_q    <= mode;
                        start_q   <= ftw_start;
                        step_q    <= ftw_step;
                        stop_q    <= ftw_stop;
                        dwell_q   <= eff_dwell;
                        ftw_out   <= ftw_start;
                        ftw_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= DWELL;
                    end
                end
                DWELL: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (expire) begin
                        if (!pass_end) begin
                            ftw_out   <= (sum >= {1'b0, stop_q}) ? stop_q : sum[FTW_W-1:0];
                            ftw_valid <= 1'b1;
                        end else begin
                            done <= 1'b1;
                            if (mode_q == MODE_SINGLE) begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                ftw_out   <= start_q;
                                ftw_valid <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Scoreboard bench for ddfs_sweep_ctrl: a sweep model queues expected output events,
// a monitor pops and compares them whenever ftw_valid or done is seen.
module tb_ddfs_sweep_ctrl;

    localparam int W  = 16;
    localparam int DW = 16;

    logic          clk_in = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          mode = 1'b0;
    logic [W-1:0]  ftw_start = '0;
    logic [W-1:0]  ftw_step = '0;
    logic [W-1:0]  ftw_stop = '0;
    logic [DW-1:0] dwell = '0;
    logic [W-1:0]  ftw_out;
    logic          ftw_valid;
    logic          busy;
    logic          done;

    ddfs_sweep_ctrl #(.FTW_W(W), .DWELL_W(DW)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .ftw_start (ftw_start),
        .ftw_step  (ftw_step),
        .ftw_stop  (ftw_stop),
        .dwell     (dwell),
        .ftw_out   (ftw_out),
        .ftw_valid (ftw_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic         v;
        logic         d;
        logic [W-1:0] ftw;
        logic         b;
    } ev_t;

    ev_t evq[$];
    int  vals[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output event must match the head of the expected queue.
    always @(negedge clk_in) begin : monitor
        ev_t e;
        if (!reset && (ftw_valid || done)) begin
            checks++;
            if (evq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: cycle %0d valid %b done %b ftw %0h busy %b, none expected",
                         cyc, ftw_valid, done, ftw_out, busy);
            end else begin
                e = evq.pop_front();
                if (e.cyc != cyc || e.v !== ftw_valid || e.d !== done || e.ftw !== ftw_out || e.b !== busy) begin
                    errors++;
                    $display("FAIL event: got cycle %0d valid %b done %b ftw %0h busy %b, expected cycle %0d valid %b done %b ftw %0h busy %b",
                             cyc, ftw_valid, done, ftw_out, busy, e.cyc, e.v, e.d, e.ftw, e.b);
                end
            end
        end
    end

    // Values of one sweep pass, from the start/step/stop arithmetic with clamping at stop.
    task automatic model_values(input int s, input int st, input int sp);
        int v;
        vals.delete();
        v = s;
        vals.push_back(v);
        while (st != 0 && v < sp) begin
            v = v + st;
            if (v >= sp) v = sp;
            vals.push_back(v);
        end
    endtask

    task automatic push_ev(input int c, input logic v, input logic d, input int f, input logic b);
        ev_t e;
        e.cyc = c; e.v = v; e.d = d; e.ftw = W'(f); e.b = b;
        evq.push_back(e);
    endtask

    // Drive a start request and queue every expected event. For loop mode the abort
    // is issued in cycle (start cycle + rel); events visible after that are not queued.
    task automatic issue(input logic m, input int s, input int st, input int sp, input int dw,
                         input int rel, output int end_cyc, output int last);
        int d, n, t, k, sc;
        @(negedge clk_in);
        mode = m; ftw_start = W'(s); ftw_step = W'(st); ftw_stop = W'(sp);
        dwell = DW'(dw); start = 1'b1; abort = 1'b0;
        sc = cyc;
        d = (dw == 0) ? 1 : dw;
        model_values(s, st, sp);
        n = vals.size();
        t = sc + 1;
        if (!m) begin
            for (int i = 0; i < n; i++) push_ev(t + i * d, 1'b1, 1'b0, vals[i], 1'b1);
            end_cyc = t + n * d;
            push_ev(end_cyc, 1'b0, 1'b1, vals[n-1], 1'b0);
            last = vals[n-1];
        end else begin
            end_cyc = sc + rel;
            k = 0;
            last = vals[0];
            while (t <= end_cyc) begin
                push_ev(t, 1'b1, (k == 0 && t != sc + 1), vals[k], 1'b1);
                last = vals[k];
                t = t + d;
                k++;
                if (k == n) k = 0;
            end
        end
    endtask

    // Run one sweep while scrambling inputs and pulsing start; single sweeps run to done,
    // loop sweeps end with an abort.
    task automatic run(input logic m, input int s, input int st, input int sp, input int dw, input int rel);
        int endc, last;
        issue(m, s, st, sp, dw, rel, endc, last);
        while (1) begin
            @(negedge clk_in);
            if (cyc >= endc) break;
            start     = 1'($urandom_range(0, 1));
            ftw_start = W'($urandom);
            ftw_step  = W'($urandom);
            ftw_stop  = W'($urandom);
            dwell     = DW'($urandom);
            mode      = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        if (m) begin
            abort = 1'b1;
            @(negedge clk_in);
            abort = 1'b0;
            #1;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_ftw_hold", 32'(ftw_out), 32'(last));
        end else begin
            @(negedge clk_in);
            #1;
            check("end_busy", 32'(busy), 32'd0);
            check("end_ftw_hold", 32'(ftw_out), 32'(last));
        end
        check("queue_drained", 32'(evq.size()), 32'd0);
        repeat (2) @(negedge clk_in);
    endtask

    initial begin : stim
        int endc, last, s, st, sp, dw, d, rel;
        logic m;

        repeat (2) @(negedge clk_in);
        #1;
        check("reset_ftw", 32'(ftw_out), 32'd0);
        check("reset_valid", 32'(ftw_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk_in);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);

        run(1'b0, 100, 50, 300, 3, 0);
        run(1'b0, 'hFF00, 'h0200, 'hFFFF, 1, 0);
        run(1'b0, 100, 50, 300, 0, 0);
        run(1'b0, 1234, 0, 5000, 3, 0);
        run(1'b0, 500, 100, 200, 2, 0);
        run(1'b1, 10, 10, 30, 2, 14);

        // abort and start together while idle: nothing happens
        @(negedge clk_in);
        abort = 1'b1; start = 1'b1;
        @(negedge clk_in);
        abort = 1'b0; start = 1'b0;
        #1;
        check("idle_abort_start_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk_in);
        check("idle_abort_start_quiet", 32'(evq.size()), 32'd0);

        // asynchronous reset in the middle of a dwell
        issue(1'b0, 100, 50, 1000, 4, 0, endc, last);
        @(negedge clk_in);
        start = 1'b0;
        repeat (5) @(negedge clk_in);
        @(posedge clk_in);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_ftw", 32'(ftw_out), 32'd0);
        check("async_reset_valid", 32'(ftw_valid), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        evq.delete();
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        run(1'b0, 40, 25, 140, 2, 0);

        for (int i = 0; i < 40; i++) begin
            m  = 1'($urandom_range(0, 1));
            dw = $urandom_range(0, 4);
            d  = (dw == 0) ? 1 : dw;
            if ($urandom_range(0, 3) == 0) begin
                s  = 65535 - $urandom_range(0, 600);
                sp = 65535 - $urandom_range(0, 300);
                st = $urandom_range(1, 6) * 100;
            end else begin
                s  = $urandom_range(0, 1000);
                sp = $urandom_range(0, 1200);
                st = $urandom_range(0, 6) * 50;
            end
            if ($urandom_range(0, 1) == 1) rel = $urandom_range(1, 12) * d;
            else rel = $urandom_range(1, 40);
            run(m, s, st, sp, dw, rel);
        end

        check("final_queue_empty", 32'(evq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
